// File: rtl/hive_ahb_pkg.sv
// Shared AHB-Lite definitions for the hive interconnect: transfer types,
// response codes and the master arbiter state encoding.
package hive_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_PARK  = 2'd0,
        ST_GRANT = 2'd1,
        ST_LOCK  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester found searching upward
// from rr_last+1, wrapping, so the previous winner is considered last.
module rr_priority_picker #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int i = 1; i <= N; i++) begin
            cand = (int'(rr_last) + i) % N;
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                idx         = IW'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Round-robin AHB-Lite master arbiter with locked-sequence support and a
// per-owner beat limit that forces re-arbitration of long unlocked bursts.
module ahb_master_arbiter
    import hive_ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int MW             = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_HOLD       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic [MW-1:0]          hmaster_d,
    output logic                   hmastlock
);

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0]          HOLD_LIMIT = CW'(MAX_HOLD);
    localparam logic [MW-1:0]          DEF_IDX    = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT  = NUM_MASTERS'(1) << DEFAULT_MASTER;

    arb_state_t             state, state_nxt;
    logic [NUM_MASTERS-1:0] hgrant_nxt;
    logic [MW-1:0]          hmaster_nxt;
    logic [MW-1:0]          rr_last, rr_last_nxt;
    logic [CW-1:0]          beat_cnt, beat_cnt_nxt;

    logic [NUM_MASTERS-1:0] win_grant;
    logic [MW-1:0]          win_idx;
    logic                   win_valid;
    logic                   is_beat;
    logic                   others_req;
    logic                   arb_ok;

    rr_priority_picker #(
        .N  (NUM_MASTERS),
        .IW (MW)
    ) u_picker (
        .req     (hbusreq),
        .rr_last (rr_last),
        .grant   (win_grant),
        .idx     (win_idx),
        .valid   (win_valid)
    );

    // BUSY is deliberately neither a beat nor a release of the bus.
    assign is_beat    = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    assign others_req = |(hbusreq & ~hgrant);
    assign arb_ok     = hready && (state != ST_LOCK) &&
                        ((htrans == HTRANS_IDLE) || !hbusreq[hmaster] ||
                         ((beat_cnt >= HOLD_LIMIT) && others_req));
    assign hmastlock  = (state == ST_LOCK);

    always_comb begin
        state_nxt    = state;
        hgrant_nxt   = hgrant;
        hmaster_nxt  = hmaster;
        rr_last_nxt  = rr_last;
        beat_cnt_nxt = beat_cnt;
        if (hready) begin
            if (is_beat && (beat_cnt < HOLD_LIMIT)) begin
                beat_cnt_nxt = beat_cnt + CW'(1);
            end
            if (state == ST_LOCK) begin
                if (!hlock[hmaster]) begin
                    state_nxt = ST_GRANT;
                end
            end else if (arb_ok) begin
                if (win_valid) begin
                    hgrant_nxt  = win_grant;
                    hmaster_nxt = win_idx;
                    rr_last_nxt = win_idx;
                    state_nxt   = hlock[win_idx] ? ST_LOCK : ST_GRANT;
                end else begin
                    hgrant_nxt  = DEF_GRANT;
                    hmaster_nxt = DEF_IDX;
                    state_nxt   = ST_PARK;
                end
            end
            // A new owner starts its beat budget from zero.
            if (hmaster_nxt != hmaster) begin
                beat_cnt_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_PARK;
            hgrant    <= DEF_GRANT;
            hmaster   <= DEF_IDX;
            hmaster_d <= DEF_IDX;
            rr_last   <= DEF_IDX;
            beat_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            hgrant   <= hgrant_nxt;
            hmaster  <= hmaster_nxt;
            rr_last  <= rr_last_nxt;
            beat_cnt <= beat_cnt_nxt;
            if (hready) begin
                hmaster_d <= hmaster;
            end
        end
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Bench for ahb_master_arbiter (2 masters, MAX_HOLD=4): directed vector table,
// hand sequences for lock/stall/reset, then random traffic against a reference model.
module tb_ahb_master_arbiter;
    import hive_ahb_pkg::*;

    localparam int N    = 2;
    localparam int MAXH = 4;
    localparam int S_PARK = 0, S_GRANT = 1, S_LOCK = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] hbusreq, hlock;
    logic [1:0]   htrans;
    logic         hready;
    logic [N-1:0] hgrant;
    logic [0:0]   hmaster, hmaster_d;
    logic         hmastlock;

    ahb_master_arbiter #(
        .NUM_MASTERS    (N),
        .MW             (1),
        .DEFAULT_MASTER (0),
        .MAX_HOLD       (MAXH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hready    (hready),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmaster_d (hmaster_d),
        .hmastlock (hmastlock)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: owner indices and counts as plain integers.
    int m_owner, m_owner_d, m_state, m_last, m_beats;

    typedef struct {
        logic [1:0] req;
        logic [1:0] lk;
        logic [1:0] tr;
        logic       rdy;
        logic [1:0] g;
        int         hm;
        int         hmd;
        logic       ml;
        int         bc;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_step(input logic r, input logic [1:0] req, input logic [1:0] lk,
                              input logic [1:0] tr, input logic rdy);
        int  old, nxt, beats_n, c;
        bit  arb, others, found;
        if (r) begin
            m_owner = 0; m_owner_d = 0; m_state = S_PARK; m_last = 0; m_beats = 0;
        end else if (rdy) begin
            old = m_owner; nxt = m_owner; beats_n = m_beats;
            if ((tr == 2'b10 || tr == 2'b11) && m_beats < MAXH) beats_n++;
            if (m_state == S_LOCK) begin
                if (!lk[old]) m_state = S_GRANT;
            end else begin
                others = 0;
                for (int i = 0; i < N; i++) if (i != old && req[i]) others = 1;
                arb = (tr == 2'b00) || !req[old] || (m_beats >= MAXH && others);
                if (arb) begin
                    found = 0;
                    for (int k = 1; k <= N; k++) begin
                        c = (m_last + k) % N;
                        if (!found && req[c]) begin found = 1; nxt = c; end
                    end
                    if (found) begin
                        m_last  = nxt;
                        m_state = lk[nxt] ? S_LOCK : S_GRANT;
                    end else begin
                        nxt     = 0;
                        m_state = S_PARK;
                    end
                end
            end
            if (nxt != old) beats_n = 0;
            m_owner = nxt; m_owner_d = old; m_beats = beats_n;
        end
    endtask

    task automatic step(input logic r, input logic [1:0] req, input logic [1:0] lk,
                        input logic [1:0] tr, input logic rdy);
        rst = r; hbusreq = req; hlock = lk; htrans = tr; hready = rdy;
        @(posedge clk);
        model_step(r, req, lk, tr, rdy);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] g, input int hm,
                              input int hmd, input logic ml, input int bc);
        check({tag, ".hgrant"},    32'(hgrant),       32'(g));
        check({tag, ".hmaster"},   32'(hmaster),      32'(hm));
        check({tag, ".hmaster_d"}, 32'(hmaster_d),    32'(hmd));
        check({tag, ".hmastlock"}, 32'(hmastlock),    32'(ml));
        check({tag, ".beat_cnt"},  32'(dut.beat_cnt), 32'(bc));
    endtask

    task automatic expect_model(input string tag);
        expect_out(tag, 2'(1 << m_owner), m_owner, m_owner_d, (m_state == S_LOCK), m_beats);
    endtask

    initial begin
        rst = 1'b1; hbusreq = '0; hlock = '0; htrans = HTRANS_IDLE; hready = 1'b1;

        // Parked, rr_last=0: master 1 wins; then a 5-beat burst with both requesting.
        tbl[0] = '{2'b10, 2'b00, HTRANS_IDLE,   1'b1, 2'b10, 1, 0, 1'b0, 0};
        tbl[1] = '{2'b11, 2'b00, HTRANS_NONSEQ, 1'b1, 2'b10, 1, 1, 1'b0, 1};
        tbl[2] = '{2'b11, 2'b00, HTRANS_SEQ,    1'b1, 2'b10, 1, 1, 1'b0, 2};
        tbl[3] = '{2'b11, 2'b00, HTRANS_SEQ,    1'b1, 2'b10, 1, 1, 1'b0, 3};
        tbl[4] = '{2'b11, 2'b00, HTRANS_SEQ,    1'b1, 2'b10, 1, 1, 1'b0, 4};
        tbl[5] = '{2'b11, 2'b00, HTRANS_SEQ,    1'b1, 2'b01, 0, 1, 1'b0, 0};
        tbl[6] = '{2'b11, 2'b00, HTRANS_NONSEQ, 1'b1, 2'b01, 0, 0, 1'b0, 1};

        step(1'b1, 2'b00, 2'b00, HTRANS_IDLE, 1'b1);
        step(1'b1, 2'b00, 2'b00, HTRANS_IDLE, 1'b1);
        expect_out("reset", 2'b01, 0, 0, 1'b0, 0);

        for (int i = 0; i < 20; i++) begin
            step(1'b0, 2'b00, 2'b00, HTRANS_IDLE, 1'b1);
            expect_out("park", 2'b01, 0, 0, 1'b0, 0);
            check("park.state", 32'(dut.state), 32'(ST_PARK));
        end

        for (int i = 0; i < 7; i++) begin
            step(1'b0, tbl[i].req, tbl[i].lk, tbl[i].tr, tbl[i].rdy);
            expect_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].hm, tbl[i].hmd, tbl[i].ml, tbl[i].bc);
        end

        // Locked burst by master 1 ignores the beat limit.
        step(1'b0, 2'b10, 2'b10, HTRANS_IDLE, 1'b1);
        expect_out("lock.win", 2'b10, 1, 0, 1'b1, 0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 2'b11, 2'b10, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1);
            expect_out("lock.hold", 2'b10, 1, 1, 1'b1, (i + 1 < MAXH) ? i + 1 : MAXH);
        end
        step(1'b0, 2'b11, 2'b00, HTRANS_SEQ, 1'b1);
        expect_out("lock.drop", 2'b10, 1, 1, 1'b0, MAXH);
        step(1'b0, 2'b11, 2'b00, HTRANS_SEQ, 1'b1);
        expect_out("lock.rearb", 2'b01, 0, 1, 1'b0, 0);

        // Stall: everything frozen while requests change, re-arbitrate on release.
        step(1'b0, 2'b01, 2'b00, HTRANS_NONSEQ, 1'b1);
        expect_out("stall.pre", 2'b01, 0, 0, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, (i < 2) ? 2'b01 : 2'b10, 2'b00, HTRANS_SEQ, 1'b0);
            expect_out("stall.hold", 2'b01, 0, 0, 1'b0, 1);
        end
        step(1'b0, 2'b10, 2'b00, HTRANS_SEQ, 1'b1);
        expect_out("stall.release", 2'b10, 1, 0, 1'b0, 0);

        // Reset in the middle of master 1's burst with the bus stalled.
        step(1'b0, 2'b10, 2'b00, HTRANS_NONSEQ, 1'b1);
        expect_out("burst", 2'b10, 1, 1, 1'b0, 1);
        step(1'b1, 2'b10, 2'b10, HTRANS_SEQ, 1'b0);
        expect_out("midrst", 2'b01, 0, 0, 1'b0, 0);
        check("midrst.state", 32'(dut.state), 32'(ST_PARK));

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) != 0));
            expect_model($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
